// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters.
// Sequences accept, compute and respond with one operation in flight at a time.
module add_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [IDW-1:0]           resp_id,
   output logic [WIDTH:0]           resp_sum,
   output logic                     busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDW-1:0]   last_grant_q;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH:0]   sum_q;

   logic             pick_found;
   logic [IDW-1:0]   pick;
   logic [WIDTH-1:0] sel_a, sel_b;

   // First pending requester after the last grant, wrapping around.
   always_comb begin : p_pick
      int unsigned idx;
      idx        = 0;
      pick_found = 1'b0;
      pick       = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_grant_q) + k) % NUM_REQ;
         if (!pick_found && req_valid[idx]) begin
            pick_found = 1'b1;
            pick       = IDW'(idx);
         end
      end
   end

   assign sel_a = req_a[32'(pick)*WIDTH +: WIDTH];
   assign sel_b = req_b[32'(pick)*WIDTH +: WIDTH];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_found) state_d = CALC;
         CALC:    state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(NUM_REQ - 1);
         id_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         sum_q        <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && pick_found) begin
            a_q          <= sel_a;
            b_q          <= sel_b;
            id_q         <= pick;
            last_grant_q <= pick;
         end
         if (state_q == CALC) begin
            sum_q <= {1'b0, a_q} + {1'b0, b_q};
         end
      end
   end

   assign req_ready  = (state_q == IDLE && pick_found) ? (NUM_REQ'(1) << pick) : '0;
   assign busy       = (state_q != IDLE);
   assign resp_valid = (state_q == RESP);
   // Response fields read as zero outside RESP.
   assign resp_id    = resp_valid ? id_q : '0;
   assign resp_sum   = resp_valid ? sum_q : '0;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed vector table, hand-written reset
// sequences and randomized operations checked against a round-robin model.
module tb_add_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_a, req_b;
   logic [3:0]  req_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_id;
   logic [4:0]  resp_sum;
   logic        busy;

   int errors = 0;
   int checks = 0;

   add_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [15:0] a;
      logic [15:0] b;
      int          bp;
      int          exp_id;
      int          exp_sum;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: first set bit searching upward from lg+1, wrapping.
   function automatic int rr_pick(input int lg, input logic [3:0] v);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (lg + k) % 4;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic do_op(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                        input int bp, input int eid, input int esum);
      logic [3:0] exp_rdy;
      exp_rdy    = 4'b0001 << eid;
      req_valid  = v;
      req_a      = a;
      req_b      = b;
      resp_ready = 1'b0;
      #1;
      chk("accept_ready", req_ready, exp_rdy);
      chk("accept_busy", busy, 0);
      chk("accept_resp_valid", resp_valid, 0);
      @(negedge clk);
      #1;
      chk("calc_ready", req_ready, 0);
      chk("calc_busy", busy, 1);
      chk("calc_resp_valid", resp_valid, 0);
      @(negedge clk);
      for (int i = 0; i <= bp; i++) begin
         #1;
         chk("resp_valid", resp_valid, 1);
         chk("resp_id", resp_id, eid);
         chk("resp_sum", resp_sum, esum);
         chk("resp_ready_zero", req_ready, 0);
         chk("resp_busy", busy, 1);
         if (i < bp) @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid  = '0;
      #1;
      chk("done_busy", busy, 0);
      chk("done_resp_valid", resp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          model_lg;
      int          g;
      int          esum;
      logic [3:0]  v;
      logic [15:0] a, b;

      //            rst   valid    a         b         bp id sum
      tbl.push_back('{1'b1, 4'b0010, 16'h0040, 16'h0040, 0, 1, 8});
      tbl.push_back('{1'b0, 4'b0001, 16'h000F, 16'h000F, 0, 0, 30});
      tbl.push_back('{1'b0, 4'b0001, 16'h0000, 16'h0000, 0, 0, 0});
      tbl.push_back('{1'b1, 4'b1111, 16'h3210, 16'h5555, 0, 0, 5});
      tbl.push_back('{1'b0, 4'b1111, 16'h3210, 16'h5555, 0, 1, 6});
      tbl.push_back('{1'b0, 4'b1111, 16'h3210, 16'h5555, 0, 2, 7});
      tbl.push_back('{1'b0, 4'b1111, 16'h3210, 16'h5555, 0, 3, 8});
      tbl.push_back('{1'b0, 4'b1111, 16'h3210, 16'h5555, 0, 0, 5});
      tbl.push_back('{1'b0, 4'b1000, 16'h1000, 16'h1000, 0, 3, 2});
      tbl.push_back('{1'b0, 4'b0101, 16'h0402, 16'h0403, 0, 0, 5});
      tbl.push_back('{1'b0, 4'b0101, 16'h0402, 16'h0403, 0, 2, 8});
      tbl.push_back('{1'b0, 4'b1111, 16'h9876, 16'h1234, 5, 3, 10});
      tbl.push_back('{1'b0, 4'b1111, 16'h9876, 16'h1234, 0, 0, 10});

      rst_n      = 1'b0;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;
      #2;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_sum", resp_sum, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         do_op(tbl[i].valid, tbl[i].a, tbl[i].b, tbl[i].bp, tbl[i].exp_id, tbl[i].exp_sum);
      end

      // Reset during CALC discards the pending result; priority restarts.
      do_reset();
      req_valid = 4'b0001;
      req_a     = 16'h0007;
      req_b     = 16'h0007;
      #1;
      chk("rc_accept", req_ready, 4'b0001);
      @(negedge clk);
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rc_resp_valid", resp_valid, 0);
      chk("rc_busy", busy, 0);
      chk("rc_req_ready", req_ready, 0);
      chk("rc_resp_id", resp_id, 0);
      chk("rc_resp_sum", resp_sum, 0);
      @(negedge clk);
      #1;
      chk("rc_resp_valid_hold", resp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(4'b1000, 16'h5000, 16'h6000, 0, 3, 11);

      // Reset during RESP: after grant 1, a non-reset search would start at 2.
      do_reset();
      req_valid = 4'b0010;
      req_a     = 16'h0030;
      req_b     = 16'h0010;
      #1;
      chk("rr_accept", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      chk("rr_resp_valid", resp_valid, 1);
      chk("rr_resp_sum", resp_sum, 4);
      rst_n = 1'b0;
      #1;
      chk("rr_resp_valid_drop", resp_valid, 0);
      chk("rr_resp_sum_zero", resp_sum, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(4'b1010, 16'h7020, 16'h1010, 0, 1, 3);

      // Randomized operations against the round-robin model.
      do_reset();
      model_lg = 3;
      repeat (40) begin
         if ($urandom_range(0, 4) == 0) begin
            req_valid = '0;
            #1;
            chk("idle_ready", req_ready, 0);
            chk("idle_busy", busy, 0);
            @(negedge clk);
         end
         v    = 4'($urandom_range(1, 15));
         a    = 16'($urandom);
         b    = 16'($urandom);
         g    = rr_pick(model_lg, v);
         esum = int'(a[g*4 +: 4]) + int'(b[g*4 +: 4]);
         model_lg = g;
         do_op(v, a, b, $urandom_range(0, 2), g, esum);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
